// File: rtl/sbox_fwd_serial.sv
// sbox_fwd_serial: AES forward S-box applied byte-serially to an NBYTES-wide word.
module sbox_fwd_serial #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] pi0,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] po0
);
  localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
  // Entry for x sits at bits [8*(255-x) +: 8], i.e. S(0) is the leading byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [8*NBYTES-1:0]   word_q, word_d, res_q, res_d;
  logic [7:0]            sub_in, sub_out;
  assign sub_in    = word_q[8*idx_q +: 8];
  assign sub_out   = SBOX_TBL[{~sub_in, 3'b000} +: 8];
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign po0       = res_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        word_d  = pi0;
        idx_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        res_d[8*idx_q +: 8] = sub_out;
        idx_d   = idx_q == LAST ? '0 : idx_q + 1'b1;
        state_d = idx_q == LAST ? DONE : BUSY;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      res_q   <= res_d;
    end
  end
endmodule

// File: tb/tb_sbox_fwd_serial.sv
// tb_sbox_fwd_serial: directed vectors plus an all-values lane sweep against a GF(2^8) model.
module tb_sbox_fwd_serial;
  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] pi0, po0;
  int          n_chk = 0, n_pass = 0;
  logic [7:0]  ginv [256];

  sbox_fwd_serial #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .pi0(pi0),
    .out_valid(out_valid), .out_ready(out_ready), .po0(po0)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0, x = a, y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] b = ginv[x];
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sboxinv_m(input logic [7:0] y);
    return ginv[rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_timeout"}, out_valid, 1);
  endtask

  // Exact latency: out_valid low after accept edge and the next three, high after the fourth, for one cycle.
  task automatic run_word(input string tag, input logic [31:0] w, input logic [31:0] exp);
    chk({tag, "_in_ready"}, in_ready, 1);
    pi0 = w;
    in_valid = 1;
    out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    chk({tag, "_busy_in_ready"}, in_ready, 0);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_early_valid"}, out_valid, 0);
      @(negedge clk);
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_po0"}, po0, exp);
    @(negedge clk);
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_idle"}, in_ready, 1);
    chk({tag, "_po0_hold"}, po0, exp);
  endtask

  task automatic sweep_word(input logic [31:0] w);
    logic [31:0] exp;
    logic [7:0]  r;
    for (int l = 0; l < 4; l++) exp[8*l +: 8] = sbox_m(w[8*l +: 8]);
    pi0 = w;
    in_valid = 1;
    out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    wait_valid("sweep");
    chk("sweep_po0", po0, exp);
    for (int l = 0; l < 4; l++) begin
      r = po0[8*l +: 8];
      chk("sweep_inv", {24'h0, sboxinv_m(r)}, {24'h0, w[8*l +: 8]});
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] held;
    logic [7:0]  b;
    for (int x = 0; x < 256; x++) begin
      ginv[x] = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) ginv[x] = 8'(y);
    end
    rst_n = 0;
    in_valid = 0;
    out_ready = 0;
    pi0 = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_po0", po0, 0);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    run_word("single", 32'h5301FF00, 32'hED7C1663);
    run_word("boundary", 32'h52000102, 32'h00637C77);

    // Back-pressure with noisy input side
    pi0 = 32'h0;
    in_valid = 1;
    out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    wait_valid("bp");
    held = 32'h63636363;
    for (int k = 0; k < 10; k++) begin
      chk("bp_po0", po0, held);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      pi0 = $urandom;
      in_valid = 1;
      @(negedge clk);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_idle", in_ready, 1);
    chk("bp_release_po0", po0, held);

    // in_valid held high, pi0 churning while busy
    pi0 = 32'h01020304;
    in_valid = 1;
    out_ready = 1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      pi0 = $urandom;
      chk("hold_early_valid", out_valid, 0);
      chk("hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    chk("hold_valid", out_valid, 1);
    chk("hold_po0", po0, 32'h7C777BF2);
    chk("hold_done_in_ready", in_ready, 0);
    @(negedge clk);
    chk("hold_ready_rise", in_ready, 1);
    chk("hold_valid_drop", out_valid, 0);
    in_valid = 0;
    @(negedge clk);

    // Reset mid-word at byte index 2
    pi0 = 32'h5301FF00;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_po0", po0, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_no_result", out_valid, 0);
    end
    chk("abort_po0_after", po0, 0);
    run_word("after_abort", 32'h52000102, 32'h00637C77);

    for (int v = 0; v < 256; v++) begin
      b = 8'(v);
      sweep_word({b + 8'd3, b + 8'd2, b + 8'd1, b});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
